uart_cmd_responder: RTL
=======================

// Module: uart_cmd_responder
// PURPOSE
//  Host-side responder on the FIFO side of the UART core: drains the Rx FIFO, decodes binary
//  command frames, performs register reads/writes on a simple local bus, and queues response
//  bytes into the Tx FIFO. Turns the UART into a register-access port for the rest of the design.
// PARAMETERS
//  DBITS       8      data word width; must match the UART core
//  ADDR_W      4      register address width; valid addresses are 0 .. 2**ADDR_W-1
//  TIMEOUT_CYC 100000 max idle clocks between bytes of one frame before abort (>=2)
// PORTS
//  clk        in   1        system clock
//  reset      in   1        synchronous, active-high reset
//  rx_empty   in   1        Rx FIFO empty
//  read_data  in   DBITS    Rx FIFO head word, valid while rx_empty=0
//  read_uart  out  1        Rx FIFO pop, one-cycle pulse
//  tx_full    in   1        Tx FIFO full
//  write_uart out  1        Tx FIFO push, one-cycle pulse
//  write_data out  DBITS    Tx FIFO write word, valid with write_uart
//  reg_addr   out  ADDR_W   local-bus address
//  reg_wdata  out  DBITS    local-bus write data
//  reg_we     out  1        local-bus write strobe, one cycle
//  reg_re     out  1        local-bus read strobe, one cycle
//  reg_rdata  in   DBITS    local-bus read data, sampled 1 clk after reg_re
//  busy       out  1        high whenever state != IDLE
//  frame_err  out  1        one-cycle pulse on NAK or timeout
// BEHAVIOUR
//  Frames: WRITE = 0x57,addr,data -> reply 0x06 (ACK). READ = 0x52,addr -> reply one data byte.
//   Unknown command byte -> reply 0x15 (NAK) immediately; no further bytes consumed.
//   Address byte with any bit >= ADDR_W set -> remaining bytes still consumed, reply NAK, no bus op.
//  States: IDLE, GET_ADDR, GET_DATA, GET_CSUM (macro only), BUS_RD, BUS_WAIT, SEND.
//  Byte intake (IDLE/GET_*): when rx_empty=0 and no pop was issued last cycle, capture read_data and
//   assert read_uart (registered, one cycle) at the same edge. Next capture is at least 2 clks later.
//  IDLE: 0x57 -> GET_ADDR(wr); 0x52 -> GET_ADDR(rd); other -> SEND with NAK.
//  GET_ADDR -> GET_DATA (write) or BUS_RD (read); bad address goes to SEND(NAK) after its last byte.
//  GET_DATA -> reg_we=1 one cycle with reg_addr/reg_wdata valid -> SEND(ACK).
//  BUS_RD: reg_re=1 one cycle -> BUS_WAIT: latch reg_rdata into tx byte -> SEND.
//  SEND: when tx_full=0, write_uart=1 for one cycle with write_data -> IDLE. Stays in SEND while
//   tx_full=1 (no drop, no timeout in SEND).
//  Timeout: in GET_* states, counter clears on each captured byte and increments while rx_empty=1;
//   at TIMEOUT_CYC-1 -> IDLE, frame_err pulse, no reply, no bus op. Counter is 0 outside GET_*.
//  frame_err pulses on the cycle SEND pushes a NAK and on timeout abort.
//  Reset (any state, incl. mid-frame): state=IDLE; read_uart, write_uart, reg_we, reg_re, busy,
//   frame_err = 0; write_data, reg_addr, reg_wdata = 0; timeout counter = 0. Partial frame discarded;
//   bytes remaining in the Rx FIFO are parsed as a new frame.
//  Latency (no backpressure, bytes already queued): WRITE reply pushed <= 8 clks after the
//   last-byte pop; READ reply <= 4 clks after the addr pop.
// CONFIGURATION
//  UART_CMD_CSUM_EN defined: every frame carries a trailing checksum byte = XOR of all preceding
//   frame bytes, received in GET_CSUM before any bus op. Mismatch -> no bus op, reply NAK.
//   Unknown command still NAKs at once (no checksum read).
//  Undefined: no GET_CSUM state; frames as listed above.
// TESTING
//  1 Rx FIFO 0x57,0x03,0xA5 -> reg_we once, addr=3, wdata=0xA5; Tx gets 0x06; frame_err=0.
//  2 0x52,0x03 with reg_rdata=0x5C -> reg_re once, addr=3; Tx gets 0x5C.
//  3 0x41 -> read_uart once, Tx gets 0x15, frame_err pulse; then 0x52,0x00 -> normal read reply.
//  4 0x57,0x02 then silence TIMEOUT_CYC clks -> IDLE, frame_err pulse, no reg_we, no Tx push.
//  5 Read with tx_full=1 for 20 clks -> no write_uart until tx_full=0, then exactly one push.
//  6 Reset asserted after 0x57,0x01 popped -> all outputs 0 next clk; next 0x52,0x01 decodes as read.
//  With UART_CMD_CSUM_EN: 0x57,0x03,0xA5,0xF1 -> ACK; checksum 0x00 -> NAK, no reg_we.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - UART command frame decoder driving a local register bus
// Optional trailing XOR checksum byte per frame: define UART_CMD_CSUM_EN.
module uart_cmd_responder #(
    parameter int DBITS       = 8,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [DBITS-1:0]  read_data,
    output logic              read_uart,
    input  logic              tx_full,
    output logic              write_uart,
    output logic [DBITS-1:0]  write_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DBITS-1:0]  reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DBITS-1:0]  reg_rdata,
    output logic              busy,
    output logic              frame_err
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [DBITS-1:0] CMD_WR   = DBITS'(8'h57);
    localparam logic [DBITS-1:0] CMD_RD   = DBITS'(8'h52);
    localparam logic [DBITS-1:0] BYTE_ACK = DBITS'(8'h06);
    localparam logic [DBITS-1:0] BYTE_NAK = DBITS'(8'h15);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
`ifdef UART_CMD_CSUM_EN
        GET_CSUM,
`endif
        BUS_RD,
        BUS_WAIT,
        SEND
    } state_t;

    state_t             state_q, state_d;
    logic               is_wr_q, is_wr_d;
    logic               bad_q, bad_d;
    logic               nak_q, nak_d;
    logic [DBITS-1:0]   tx_byte_q, tx_byte_d;
    logic               read_uart_q, read_uart_d;
    logic               write_uart_q, write_uart_d;
    logic [DBITS-1:0]   write_data_q, write_data_d;
    logic [ADDR_W-1:0]  reg_addr_q, reg_addr_d;
    logic [DBITS-1:0]   reg_wdata_q, reg_wdata_d;
    logic               reg_we_q, reg_we_d;
    logic               frame_err_q, frame_err_d;
    logic [TW-1:0]      tmo_q, tmo_d;
`ifdef UART_CMD_CSUM_EN
    logic [DBITS-1:0]   csum_q, csum_d;
`endif
    logic               in_get;
    logic               take;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            is_wr_q      <= 1'b0;
            bad_q        <= 1'b0;
            nak_q        <= 1'b0;
            tx_byte_q    <= '0;
            read_uart_q  <= 1'b0;
            write_uart_q <= 1'b0;
            write_data_q <= '0;
            reg_addr_q   <= '0;
            reg_wdata_q  <= '0;
            reg_we_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            tmo_q        <= '0;
`ifdef UART_CMD_CSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            is_wr_q      <= is_wr_d;
            bad_q        <= bad_d;
            nak_q        <= nak_d;
            tx_byte_q    <= tx_byte_d;
            read_uart_q  <= read_uart_d;
            write_uart_q <= write_uart_d;
            write_data_q <= write_data_d;
            reg_addr_q   <= reg_addr_d;
            reg_wdata_q  <= reg_wdata_d;
            reg_we_q     <= reg_we_d;
            frame_err_q  <= frame_err_d;
            tmo_q        <= tmo_d;
`ifdef UART_CMD_CSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        is_wr_d      = is_wr_q;
        bad_d        = bad_q;
        nak_d        = nak_q;
        tx_byte_d    = tx_byte_q;
        read_uart_d  = 1'b0;
        write_uart_d = 1'b0;
        write_data_d = write_data_q;
        reg_addr_d   = reg_addr_q;
        reg_wdata_d  = reg_wdata_q;
        reg_we_d     = 1'b0;
        frame_err_d  = 1'b0;
        tmo_d        = '0;
        reg_re       = 1'b0;
`ifdef UART_CMD_CSUM_EN
        csum_d       = csum_q;
        in_get       = (state_q == GET_ADDR) || (state_q == GET_DATA) || (state_q == GET_CSUM);
`else
        in_get       = (state_q == GET_ADDR) || (state_q == GET_DATA);
`endif
        // The pop pulse lasts a cycle; the FIFO head only advances after it, so skip that cycle.
        take = ((state_q == IDLE) || in_get) && !rx_empty && !read_uart_q;
        if (take) begin
            read_uart_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (take) begin
                    bad_d = 1'b0;
`ifdef UART_CMD_CSUM_EN
                    csum_d = read_data;
`endif
                    if (read_data == CMD_WR) begin
                        is_wr_d = 1'b1;
                        state_d = GET_ADDR;
                    end else if (read_data == CMD_RD) begin
                        is_wr_d = 1'b0;
                        state_d = GET_ADDR;
                    end else begin
                        tx_byte_d = BYTE_NAK;
                        nak_d     = 1'b1;
                        state_d   = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (take) begin
                    bad_d      = (read_data >> ADDR_W) != '0;
                    reg_addr_d = read_data[ADDR_W-1:0];
`ifdef UART_CMD_CSUM_EN
                    csum_d  = csum_q ^ read_data;
                    state_d = is_wr_q ? GET_DATA : GET_CSUM;
`else
                    if (is_wr_q) begin
                        state_d = GET_DATA;
                    end else if ((read_data >> ADDR_W) != '0) begin
                        tx_byte_d = BYTE_NAK;
                        nak_d     = 1'b1;
                        state_d   = SEND;
                    end else begin
                        state_d = BUS_RD;
                    end
`endif
                end
            end
            GET_DATA: begin
                if (take) begin
                    reg_wdata_d = read_data;
`ifdef UART_CMD_CSUM_EN
                    csum_d  = csum_q ^ read_data;
                    state_d = GET_CSUM;
`else
                    tx_byte_d = bad_q ? BYTE_NAK : BYTE_ACK;
                    nak_d     = bad_q;
                    reg_we_d  = !bad_q;
                    state_d   = SEND;
`endif
                end
            end
`ifdef UART_CMD_CSUM_EN
            GET_CSUM: begin
                if (take) begin
                    if (bad_q || (read_data != csum_q)) begin
                        tx_byte_d = BYTE_NAK;
                        nak_d     = 1'b1;
                        state_d   = SEND;
                    end else if (is_wr_q) begin
                        tx_byte_d = BYTE_ACK;
                        nak_d     = 1'b0;
                        reg_we_d  = 1'b1;
                        state_d   = SEND;
                    end else begin
                        state_d = BUS_RD;
                    end
                end
            end
`endif
            BUS_RD: begin
                reg_re  = 1'b1;
                state_d = BUS_WAIT;
            end
            BUS_WAIT: begin
                tx_byte_d = reg_rdata;
                nak_d     = 1'b0;
                state_d   = SEND;
            end
            SEND: begin
                if (!tx_full) begin
                    write_uart_d = 1'b1;
                    write_data_d = tx_byte_q;
                    frame_err_d  = nak_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (in_get && !take && rx_empty) begin
            if (tmo_q == TMO_LAST) begin
                state_d     = IDLE;
                frame_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else if (in_get && !take) begin
            tmo_d = tmo_q;
        end
    end

    assign read_uart  = read_uart_q;
    assign write_uart = write_uart_q;
    assign write_data = write_data_q;
    assign reg_addr   = reg_addr_q;
    assign reg_wdata  = reg_wdata_q;
    assign reg_we     = reg_we_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule
